// File: rtl/updi_pkg.sv
// Shared UPDI definitions: instruction opcodes, protocol constants and the frame TX state type.
// The BREAK state exists only when UPDI_BREAK_EN is defined.
package updi_pkg;

  typedef enum logic [2:0] {
    UPDI_LDS    = 3'h0,
    UPDI_LD     = 3'h1,
    UPDI_STS    = 3'h2,
    UPDI_ST     = 3'h3,
    UPDI_LDCS   = 3'h4,
    UPDI_REPEAT = 3'h5,
    UPDI_STCS   = 3'h6,
    UPDI_KEY    = 3'h7
  } updi_instruction;

  localparam logic [7:0] UPDI_SYNCH      = 8'h55;
  localparam int         UPDI_BREAK_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef UPDI_BREAK_EN
    ST_BREAK,
`endif
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } updi_tx_state_t;

  // Even parity bit: makes the count of ones over data+parity even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/updi_frame_tx_if.sv
// Byte request handshake between the opcode converter (master) and the frame transmitter (slave).
interface updi_frame_tx_if;
  logic [7:0] in_data;
  logic       in_sync;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_sync, output in_valid, input in_ready);
  modport slave  (input in_data, input in_sync, input in_valid, output in_ready);
endinterface

// File: rtl/updi_baud_gen.sv
// Bit-time generator: counts CLKS_PER_BIT clocks and pulses bit_tick on the last clock of each bit.
// restart holds the counter at zero so the first bit after leaving idle is full length.
module updi_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int              CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_tick = !restart && (cnt == LAST);

endmodule

// File: rtl/updi_frame_tx.sv
// UPDI frame serialiser: start, 8 data LSB-first, even parity, STOP_BITS stops, optional SYNCH prefix.
// Define UPDI_BREAK_EN to add the BREAK generator driven by send_break.
module updi_frame_tx
  import updi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 2
) (
  input  logic          clk,
  input  logic          rst,
  updi_frame_tx_if.slave bus,
  input  logic          send_break,
  output logic          updi_tx,
  output logic          tx_oe,
  output logic          busy,
  output logic          done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("updi_frame_tx: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("updi_frame_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic LAST_STOP = (STOP_BITS == 2);

  updi_tx_state_t state, state_d;
  logic [2:0]     bit_cnt, bit_cnt_d;
  logic           stop_cnt, stop_cnt_d;
  logic           sync_pend, sync_pend_d;
  logic           done_d, tx_d, oe_d;
  logic [7:0]     shreg, shreg_d;
  logic [7:0]     data_q, data_d;
  logic           par, par_d;
  logic           bit_tick, accept;
  logic [7:0]     load_byte;

`ifdef UPDI_BREAK_EN
  logic [4:0]     brk_cnt, brk_cnt_d;
  assign bus.in_ready = (state == ST_IDLE) && !rst && !send_break;
`else
  logic unused_send_break;
  assign unused_send_break = send_break;
  assign bus.in_ready      = (state == ST_IDLE) && !rst;
`endif

  assign accept    = bus.in_valid && bus.in_ready;
  assign busy      = (state != ST_IDLE);
  assign load_byte = bus.in_sync ? UPDI_SYNCH : bus.in_data;

  updi_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (state == ST_IDLE),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    stop_cnt_d  = stop_cnt;
    sync_pend_d = sync_pend;
    shreg_d     = shreg;
    data_d      = data_q;
    par_d       = par;
    done_d      = 1'b0;
`ifdef UPDI_BREAK_EN
    brk_cnt_d   = brk_cnt;
`endif
    case (state)
      ST_IDLE: begin
`ifdef UPDI_BREAK_EN
        if (send_break) begin
          state_d   = ST_BREAK;
          brk_cnt_d = '0;
        end
`endif
        if (accept) begin
          state_d     = ST_START;
          sync_pend_d = bus.in_sync;
          data_d      = bus.in_data;
          shreg_d     = load_byte;
          par_d       = even_parity(load_byte);
          bit_cnt_d   = '0;
        end
      end
`ifdef UPDI_BREAK_EN
      // Break bits 0..23 hold the line low; count 24 is the high delimiter bit.
      ST_BREAK: begin
        if (bit_tick) begin
          if (brk_cnt == 5'(UPDI_BREAK_BITS)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            brk_cnt_d = brk_cnt + 5'd1;
          end
        end
      end
`endif
      ST_START: begin
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          shreg_d = shreg >> 1;
          if (bit_cnt == 3'd7) state_d = ST_PARITY;
          else                 bit_cnt_d = bit_cnt + 3'd1;
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (stop_cnt == LAST_STOP) begin
            // A pending SYNCH prefix chains straight into the payload frame with no idle gap.
            if (sync_pend) begin
              state_d     = ST_START;
              sync_pend_d = 1'b0;
              shreg_d     = data_q;
              par_d       = even_parity(data_q);
              bit_cnt_d   = '0;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tx_d = 1'b1;
    oe_d = 1'b1;
    case (state_d)
      ST_IDLE:   oe_d = 1'b0;
`ifdef UPDI_BREAK_EN
      ST_BREAK:  tx_d = (brk_cnt_d == 5'(UPDI_BREAK_BITS));
`endif
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      sync_pend <= 1'b0;
      done      <= 1'b0;
      updi_tx   <= 1'b1;
      tx_oe     <= 1'b0;
`ifdef UPDI_BREAK_EN
      brk_cnt   <= '0;
`endif
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      stop_cnt  <= stop_cnt_d;
      sync_pend <= sync_pend_d;
      done      <= done_d;
      updi_tx   <= tx_d;
      tx_oe     <= oe_d;
`ifdef UPDI_BREAK_EN
      brk_cnt   <= brk_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    shreg  <= shreg_d;
    data_q <= data_d;
    par    <= par_d;
  end

endmodule

// File: tb/tb_updi_frame_tx.sv
// Directed bench for updi_frame_tx at CLKS_PER_BIT=4, STOP_BITS=2; break sequence runs when UPDI_BREAK_EN is defined.
module tb_updi_frame_tx;

  localparam int CPB   = 4;
  localparam int NSTOP = 2;
  localparam int FBITS = 10 + NSTOP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic send_break = 1'b0;
  logic updi_tx, tx_oe, busy, done;

  updi_frame_tx_if bus();

  updi_frame_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(NSTOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .send_break (send_break),
    .updi_tx    (updi_tx),
    .tx_oe      (tx_oe),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    logic       sync;
    logic       par;
  } vec_t;

  vec_t vecs[8];

  // Observed pins packed as {updi_tx, tx_oe, done, busy, in_ready}.
  function automatic logic [4:0] pins();
    return {updi_tx, tx_oe, done, busy, bus.in_ready};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic present(input logic [7:0] d, input logic s);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready before request", 32'(bus.in_ready), 32'd1);
    bus.in_data  = d;
    bus.in_sync  = s;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;
    bus.in_sync  = ~s;
  endtask

  task automatic check_frame(input logic [7:0] d, input logic p, input string tag);
    logic [FBITS-1:0] bits;
    bits = {{NSTOP{1'b1}}, p, d, 1'b0};
    for (int b = 0; b < FBITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        chk($sformatf("%s bit%0d cyc%0d pins", tag, b, c), 32'(pins()), 32'({bits[b], 4'b1010}));
      end
    end
  endtask

  task automatic check_done(input string tag);
    @(negedge clk);
    chk($sformatf("%s done cycle pins", tag), 32'(pins()), 32'(5'b10101));
  endtask

  initial begin
    int dn;
    vecs[0] = '{8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'h80, 1'b1, 1'b1};
    vecs[2] = '{8'h24, 1'b0, 1'b0};
    vecs[3] = '{8'hA5, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'h7F, 1'b1, 1'b1};

    bus.in_data  = 8'h00;
    bus.in_sync  = 1'b0;
    bus.in_valid = 1'b0;

    // Reset held three cycles
    repeat (3) begin
      @(negedge clk);
      chk("reset pins", 32'(pins()), 32'(5'b10000));
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready after reset", 32'(pins()), 32'(5'b10001));

    // Table-driven single and SYNCH-prefixed frames
    for (int i = 0; i < 8; i++) begin
      present(vecs[i].data, vecs[i].sync);
      if (vecs[i].sync) check_frame(8'h55, 1'b0, $sformatf("v%0d synch", i));
      check_frame(vecs[i].data, vecs[i].par, $sformatf("v%0d data", i));
      check_done($sformatf("v%0d", i));
      @(negedge clk);
      chk($sformatf("v%0d done single pulse", i), 32'(done), 32'd0);
    end

    // Back-to-back with in_valid held high
    @(negedge clk);
    bus.in_data  = 8'h24;
    bus.in_sync  = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_data = 8'hA5;
    check_frame(8'h24, 1'b0, "b2b first");
    check_done("b2b first");
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check_frame(8'hA5, 1'b0, "b2b second");
    check_done("b2b second");

    // Reset 20 cycles into a frame
    present(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid-frame reset pins", 32'(pins()), 32'(5'b10001));
    dn = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("no done after mid-frame reset", 32'(dn), 32'd0);
    present(8'h01, 1'b0);
    check_frame(8'h01, 1'b1, "after reset");
    check_done("after reset");

`ifdef UPDI_BREAK_EN
    // Break and byte requested together: break wins, byte follows
    @(negedge clk);
    send_break   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    bus.in_sync  = 1'b0;
    #1 chk("break blocks in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 send_break = 1'b0;
    for (int i = 0; i < 25 * CPB; i++) begin
      @(negedge clk);
      chk($sformatf("break cyc%0d pins", i), 32'(pins()), 32'({(i >= 24 * CPB), 4'b1010}));
    end
    check_done("break");
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check_frame(8'h3C, 1'b0, "after break");
    check_done("after break");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
